ram256x32_arbiter: RTL

RAM256X32_ARBITER -- requirements
Module: ram256x32_arbiter

---
 rtl/ram256x32_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram256x32_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous single-port-pair RAM,
// with a clear sweep that zero-fills every word while arbitration is suspended.
module ram256x32_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              r0_valid,
    input  logic              r1_valid,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ready,
    output logic              r1_ready,
    output logic              r0_rsp_valid,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    input  logic              clear,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_sweepAddr;
    logic              r_lastGrant;
    logic              r_rspPend0;
    logic              r_rspPend1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_grant0;
    logic              w_grant1;

    // Outputs are gated by reset so nothing is granted or written while reset is held.
    always_comb begin
        w_nextState = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        busy        = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        ram_raddr   = '0;
        if (i_rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        w_nextState = S_CLEAR;
                    end else if (r0_valid && (!r1_valid || r_lastGrant)) begin
                        w_grant0 = 1'b1;
                    end else if (r1_valid) begin
                        w_grant1 = 1'b1;
                    end
                    if (w_grant0) begin
                        ram_we    = r0_we;
                        ram_re    = !r0_we;
                        ram_waddr = r0_addr;
                        ram_wdata = r0_wdata;
                        ram_raddr = r0_addr;
                    end else if (w_grant1) begin
                        ram_we    = r1_we;
                        ram_re    = !r1_we;
                        ram_waddr = r1_addr;
                        ram_wdata = r1_wdata;
                        ram_raddr = r1_addr;
                    end
                end
                S_CLEAR: begin
                    busy      = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = r_sweepAddr;
                    if (r_sweepAddr == {ADDR_W{1'b1}}) begin
                        w_nextState = S_IDLE;
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    assign r0_ready = w_grant0;
    assign r1_ready = w_grant1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sweepAddr <= '0;
            r_lastGrant <= 1'b1;
            r_rspPend0  <= 1'b0;
            r_rspPend1  <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_nextState;
            r_sweepAddr <= (r_state == S_CLEAR) ? r_sweepAddr + 1'b1 : '0;
            if (w_grant0) begin
                r_lastGrant <= 1'b0;
            end else if (w_grant1) begin
                r_lastGrant <= 1'b1;
            end
            r_rspPend0 <= w_grant0 && !r0_we;
            r_rspPend1 <= w_grant1 && !r1_we;
            if (r_rspPend0) begin
                r_rdata0 <= ram_rdata;
            end
            if (r_rspPend1) begin
                r_rdata1 <= ram_rdata;
            end
        end
    end

    // RAM data arrives during the response cycle; the register keeps it afterwards.
    assign r0_rsp_valid = r_rspPend0;
    assign r1_rsp_valid = r_rspPend1;
    assign r0_rsp_rdata = r_rspPend0 ? ram_rdata : r_rdata0;
    assign r1_rsp_rdata = r_rspPend1 ? ram_rdata : r_rdata1;

endmodule
